// File: rtl/cmd_response_ctrl.sv
// ---------------------------------------------------------------------------
// cmd_response_ctrl
//
// Sequences the CMD-line deserializer to capture one SD command response
// after a command has been sent. It waits for the start bit (bounded by the
// Ncr timeout), programs the frame size, and enables the deserializer. It
// runs a serial CRC7 on the incoming bits, checks the CRC and the end bit,
// and hands the frame and the error flags to the command FSM.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   1-cycle pulse: expect a response (ignored unless idle)
//   resp_long      in   1 = 136-bit R2 frame, 0 = 48-bit frame; sampled on start
//   crc_check      in   1 = check CRC7 (0 for R3); sampled on start
//   cmd_in         in   raw CMD line
//   des_in         out  cmd_in registered once, feeds the deserializer input
//   des_enable     out  deserializer enable
//   des_reset      out  deserializer reset, one cycle after an accepted start
//   des_framesize  out  deserializer frame size (48 or 136)
//   des_complete   in   deserializer frame complete
//   des_out        in   deserializer frame; first bit at [framesize-1], end bit at [0]
//   busy           out  transaction in progress
//   done           out  1-cycle pulse: resp and error flags are valid
//   resp           out  captured frame, zero-extended above framesize
//   timeout_err    out  no start bit, or no des_complete, in time
//   crc_err        out  CRC7 mismatch
//   end_err        out  end bit was 0
// ---------------------------------------------------------------------------
module cmd_response_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SHORT_LEN      = 48,
    parameter int LONG_LEN       = 136,
    parameter int GUARD_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         resp_long,
    input  logic         crc_check,
    input  logic         cmd_in,
    output logic         des_in,
    output logic         des_enable,
    output logic         des_reset,
    output logic [7:0]   des_framesize,
    input  logic         des_complete,
    input  logic [135:0] des_out,
    output logic         busy,
    output logic         done,
    output logic [135:0] resp,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         end_err
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_RECEIVE    = 2'd2;
    localparam logic [1:0] S_FINISH     = 2'd3;

    localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX   = '1;

    localparam logic [7:0] SHORT_FS   = 8'(SHORT_LEN);
    localparam logic [7:0] LONG_FS    = 8'(LONG_LEN);

    // CRC7 covers everything ahead of the 7 CRC bits and the end bit; long
    // frames additionally skip their 8-bit header.
    localparam logic [8:0] SHORT_CRC_LAST = 9'(SHORT_LEN - 9);
    localparam logic [8:0] LONG_CRC_FIRST = 9'd8;
    localparam logic [8:0] LONG_CRC_LAST  = 9'(LONG_LEN - 9);

    localparam logic [135:0] ALL_ONES = '1;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [8:0]    bit_cnt;
    logic [6:0]    crc;
    logic          long_q;
    logic          crc_en_q;

    logic          crc_cov;
    logic [8:0]    rcv_limit;
    logic [135:0]  resp_mask;

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        crc_cov = 1'b0;
        if (long_q) begin
            crc_cov = (bit_cnt >= LONG_CRC_FIRST) && (bit_cnt <= LONG_CRC_LAST);
        end else begin
            crc_cov = (bit_cnt <= SHORT_CRC_LAST);
        end
    end

    assign rcv_limit = {1'b0, des_framesize} + 9'(GUARD_CYCLES);
    // Bits above the frame size are whatever the deserializer left there.
    assign resp_mask = ~(ALL_ONES << des_framesize);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            crc           <= '0;
            long_q        <= 1'b0;
            crc_en_q      <= 1'b0;
            des_in        <= 1'b1;
            des_enable    <= 1'b0;
            des_reset     <= 1'b0;
            des_framesize <= SHORT_FS;
            busy          <= 1'b0;
            done          <= 1'b0;
            resp          <= '0;
            timeout_err   <= 1'b0;
            crc_err       <= 1'b0;
            end_err       <= 1'b0;
        end else begin
            des_in    <= cmd_in;
            des_reset <= 1'b0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        long_q        <= resp_long;
                        crc_en_q      <= crc_check;
                        des_framesize <= resp_long ? LONG_FS : SHORT_FS;
                        des_reset     <= 1'b1;
                        timer         <= '0;
                        crc           <= '0;
                        bit_cnt       <= '0;
                        timeout_err   <= 1'b0;
                        crc_err       <= 1'b0;
                        end_err       <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_WAIT_START;
                    end
                end

                S_WAIT_START: begin
                    if (timer != T_MAX) begin
                        timer <= timer + 1'b1;
                    end
                    // The start bit wins over a simultaneous timeout.
                    if (!cmd_in) begin
                        des_enable <= 1'b1;
                        bit_cnt    <= 9'd1;
                        // Bit 0 is only inside the CRC range of short frames.
                        crc        <= long_q ? 7'd0 : crc7_next(7'd0, cmd_in);
                        state      <= S_RECEIVE;
                    end else if (timer == T_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_FINISH;
                    end
                end

                S_RECEIVE: begin
                    if (des_complete) begin
                        resp       <= des_out & resp_mask;
                        des_enable <= 1'b0;
                        crc_err    <= crc_en_q && (crc != des_out[7:1]);
                        end_err    <= !des_out[0];
                        done       <= 1'b1;
                        state      <= S_FINISH;
                    end else if (bit_cnt >= rcv_limit) begin
                        timeout_err <= 1'b1;
                        des_enable  <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (crc_cov) begin
                            crc <= crc7_next(crc, cmd_in);
                        end
                    end
                end

                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_response_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmd_response_ctrl
//
// Drives SD response frames on the CMD line into cmd_response_ctrl, with a
// behavioural deserializer attached. Expected results are queued when a
// transaction is started and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_cmd_response_ctrl;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int SHORT_LEN      = 48;
    localparam int LONG_LEN       = 136;
    localparam int GUARD_CYCLES   = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         resp_long;
    logic         crc_check;
    logic         cmd_in;
    logic         des_in;
    logic         des_enable;
    logic         des_reset;
    logic [7:0]   des_framesize;
    logic         des_complete;
    logic [135:0] des_out;
    logic         busy;
    logic         done;
    logic [135:0] resp;
    logic         timeout_err;
    logic         crc_err;
    logic         end_err;

    cmd_response_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SHORT_LEN      (SHORT_LEN),
        .LONG_LEN       (LONG_LEN),
        .GUARD_CYCLES   (GUARD_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .resp_long     (resp_long),
        .crc_check     (crc_check),
        .cmd_in        (cmd_in),
        .des_in        (des_in),
        .des_enable    (des_enable),
        .des_reset     (des_reset),
        .des_framesize (des_framesize),
        .des_complete  (des_complete),
        .des_out       (des_out),
        .busy          (busy),
        .done          (done),
        .resp          (resp),
        .timeout_err   (timeout_err),
        .crc_err       (crc_err),
        .end_err       (end_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural deserializer. Its register is refilled with ones on reset so
    // that stale bits sit above a short frame and the resp masking is exercised.
    logic [135:0] ds_sreg;
    logic [7:0]   ds_cnt;
    logic         ds_cmpl;

    always @(posedge clk or posedge reset) begin
        if (reset || des_reset) begin
            ds_sreg <= '1;
            ds_cnt  <= '0;
            ds_cmpl <= 1'b0;
        end else if (des_enable && !ds_cmpl) begin
            ds_sreg <= {ds_sreg[134:0], des_in};
            ds_cnt  <= ds_cnt + 8'd1;
            if (ds_cnt + 8'd1 == des_framesize) ds_cmpl <= 1'b1;
        end
    end

    assign des_complete = ds_cmpl;
    assign des_out      = ds_sreg;

    // Scoreboard
    typedef struct packed {
        logic [135:0] resp;
        logic         tmo;
        logic         crc_e;
        logic         end_e;
        logic [7:0]   fs;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [135:0] exp_last_resp;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // History of des_complete as seen on the two previous falling edges.
    logic [1:0] cmpl_h;
    logic       en_seen;

    always @(negedge clk) begin
        cmpl_h <= {cmpl_h[0], des_complete};
        if (des_enable === 1'b1) en_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 136'(1), 136'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("resp",         resp,                  mon_e.resp);
                check("timeout_err",  136'(timeout_err),     136'(mon_e.tmo));
                check("crc_err",      136'(crc_err),         136'(mon_e.crc_e));
                check("end_err",      136'(end_err),         136'(mon_e.end_e));
                check("framesize",    136'(des_framesize),   136'(mon_e.fs));
                check("busy_at_done", 136'(busy),            136'(1));
            end
        end
    end

    // Reference CRC7 as polynomial long division: the message f[msb:lsb]
    // followed by seven zeros, divided by x^7 + x^3 + 1 (0x89).
    function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int msb, input int lsb);
        logic [7:0] r;
        r = '0;
        for (int i = msb; i >= lsb - 7; i--) begin
            r = {r[6:0], (i >= lsb) ? f[i] : 1'b0};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [135:0] short_frame(input logic [7:0] hdr, input logic [31:0] arg);
        logic [135:0] f;
        f         = '0;
        f[47:40]  = hdr;
        f[39:8]   = arg;
        f[7:1]    = crc7_ref(f, 47, 8);
        f[0]      = 1'b1;
        return f;
    endfunction

    function automatic logic [135:0] long_frame(input logic [119:0] payload);
        logic [135:0] f;
        f          = '0;
        f[135:128] = 8'h3F;
        f[127:8]   = payload;
        f[7:1]     = crc7_ref(f, 127, 8);
        f[0]       = 1'b1;
        return f;
    endfunction

    task automatic start_pulse(input logic lng, input logic chk);
        @(negedge clk);
        start     = 1'b1;
        resp_long = lng;
        crc_check = chk;
        @(negedge clk);
        start = 1'b0;
        check("des_reset_pulse", 136'(des_reset), 136'(1));
        check("framesize_after_start", 136'(des_framesize), lng ? 136'(LONG_LEN) : 136'(SHORT_LEN));
        check("busy_after_start", 136'(busy), 136'(1));
    endtask

    // Idle for 'delay' cycles, then shift the frame out first bit first. A
    // start pulse is injected at bit index poke_at (negative: never).
    task automatic send_bits(input logic [135:0] f, input int len, input int delay, input int poke_at);
        for (int d = 0; d < delay; d++) @(negedge clk);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            cmd_in = f[len-1-j];
            start  = (j == poke_at);
            if (j == poke_at) begin
                resp_long = 1'b1;
                crc_check = 1'b0;
            end
        end
        @(negedge clk);
        cmd_in = 1'b1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("done_timeout", 136'(0), 136'(1));
    endtask

    task automatic run_frame(input logic [135:0] f, input logic lng, input logic chk,
                             input logic exp_crc, input logic exp_end,
                             input int delay, input int poke_at);
        exp_t e;
        int   cyc;
        e.resp  = f;
        e.tmo   = 1'b0;
        e.crc_e = exp_crc;
        e.end_e = exp_end;
        e.fs    = lng ? 8'(LONG_LEN) : 8'(SHORT_LEN);
        sb_q.push_back(e);
        exp_last_resp = f;
        start_pulse(lng, chk);
        send_bits(f, lng ? LONG_LEN : SHORT_LEN, delay, poke_at);
        wait_done(20, cyc);
        if (cyc > 0) check("complete_to_done", 136'(cmpl_h), 136'(2'b01));
        @(negedge clk);
        check("busy_after_done", 136'(busy), 136'(0));
    endtask

    task automatic check_reset_values();
        check("rst_des_in",        136'(des_in),        136'(1));
        check("rst_des_enable",    136'(des_enable),    136'(0));
        check("rst_des_reset",     136'(des_reset),     136'(0));
        check("rst_des_framesize", 136'(des_framesize), 136'(SHORT_LEN));
        check("rst_busy",          136'(busy),          136'(0));
        check("rst_done",          136'(done),          136'(0));
        check("rst_resp",          resp,                136'(0));
        check("rst_timeout_err",   136'(timeout_err),   136'(0));
        check("rst_crc_err",       136'(crc_err),       136'(0));
        check("rst_end_err",       136'(end_err),       136'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [135:0] f1;
    logic [135:0] fl;
    logic [127:0] rnd;
    exp_t         te;
    int           cyc;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_last_resp = '0;
        en_seen       = 1'b0;
        reset         = 1'b1;
        start         = 1'b0;
        resp_long     = 1'b0;
        crc_check     = 1'b0;
        cmd_in        = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // Test 1: short R1 frame, start bit after 5 idle cycles
        f1 = short_frame(8'h11, 32'h0000_0900);
        run_frame(f1, 1'b0, 1'b1, 1'b0, 1'b0, 5, -1);

        // Random valid short frames
        for (int k = 0; k < 3; k++) begin
            run_frame(short_frame(8'($urandom_range(0, 63)), 32'($urandom)),
                      1'b0, 1'b1, 1'b0, 1'b0, $urandom_range(0, 10), -1);
        end

        // Test 2: long R2 frame, valid CRC over bits 8..127
        rnd = {$urandom, $urandom, $urandom, $urandom};
        fl  = long_frame(rnd[119:0]);
        run_frame(fl, 1'b1, 1'b1, 1'b0, 1'b0, 3, -1);
        // Same frame with one payload bit flipped
        run_frame(fl ^ (136'd1 << 50), 1'b1, 1'b1, 1'b1, 1'b0, 2, -1);

        // Test 3: no start bit -> timeout, done TIMEOUT_CYCLES+1 cycles after start
        te.resp  = exp_last_resp;
        te.tmo   = 1'b1;
        te.crc_e = 1'b0;
        te.end_e = 1'b0;
        te.fs    = 8'(SHORT_LEN);
        sb_q.push_back(te);
        en_seen = 1'b0;
        start_pulse(1'b0, 1'b1);
        wait_done(TIMEOUT_CYCLES + 20, cyc);
        check("timeout_latency", 136'(cyc + 1), 136'(TIMEOUT_CYCLES + 1));
        check("timeout_no_enable", 136'(en_seen), 136'(0));
        @(negedge clk);

        // Test 4: flipped CRC bit, with and without CRC checking
        run_frame(f1 ^ (136'd1 << 3), 1'b0, 1'b1, 1'b1, 1'b0, 4, -1);
        run_frame(f1 ^ (136'd1 << 3), 1'b0, 1'b0, 1'b0, 1'b0, 4, -1);

        // Test 5: end bit 0, plus a long-frame start pulse while busy
        run_frame(f1 & ~136'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 10);
        resp_long = 1'b0;

        // Test 6: reset at bit 20 of a short frame
        start_pulse(1'b0, 1'b1);
        for (int d = 0; d < 3; d++) @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            cmd_in = f1[SHORT_LEN-1-j];
        end
        @(negedge clk);
        reset  = 1'b1;
        cmd_in = 1'b0;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        check("rst_hold_des_in", 136'(des_in), 136'(1));
        cmd_in = 1'b1;
        reset  = 1'b0;
        exp_last_resp = '0;
        repeat (2) @(negedge clk);
        run_frame(f1, 1'b0, 1'b1, 1'b0, 1'b0, 5, -1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 136'(sb_q.size()), 136'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
